feature_frame_packer: RTL

FEATURE_FRAME_PACKER -- requirements
Module: feature_frame_packer

---
 rtl/feature_frame_packer_pkg.sv | 23 ++
 rtl/feature_frame_packer_anomaly_scan.sv | 41 ++++
 rtl/feature_frame_packer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/feature_frame_packer_pkg.sv
// Shared definitions for the feature frame packer.
//   N_FEAT_DEF      - features per frame
//   FEAT_W_DEF      - bits per feature
//   FLAT_W_DEF      - width of the packed frame (N_FEAT_DEF * FEAT_W_DEF)
//   ANOM_THRESH_DEF - default anomaly threshold (feature >= threshold flags)
//   state_t         - frame packer control states
package feature_frame_packer_pkg;

  localparam int unsigned    N_FEAT_DEF      = 80;
  localparam int unsigned    FEAT_W_DEF      = 8;
  localparam int unsigned    FLAT_W_DEF      = N_FEAT_DEF * FEAT_W_DEF;
  localparam logic [7:0]     ANOM_THRESH_DEF = 8'hF0;

  // FILL : accepting bytes into the assembly buffer
  // PEND : frame complete, waiting for the output slot to free up
  // DRAIN: discarding the tail of an over-long frame until in_last
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PEND  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/feature_frame_packer_anomaly_scan.sv
// feature_anomaly_scan: per-byte threshold compare with a sticky OR that
// spans one frame. Only instantiated when FEATURE_ANOMALY_DETECT_EN is set.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   data      - feature byte under inspection
//   sample    - data is an accepted byte of the current frame
//   clear     - frame handed to the output; restart the sticky OR
//   hit       - frame-so-far anomaly, including the byte on data this cycle
module feature_anomaly_scan
  import feature_frame_packer_pkg::*;
#(
  parameter int unsigned       FEAT_W = FEAT_W_DEF,
  parameter logic [FEAT_W-1:0] THRESH = FEAT_W'(ANOM_THRESH_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FEAT_W-1:0] data,
  input  logic              sample,
  input  logic              clear,
  output logic              hit
);

  logic sticky;
  logic byte_hit;

  assign byte_hit = sample && (data >= THRESH);
  // The completing byte is seen in the same cycle the frame is loaded,
  // so it must reach hit combinationally rather than via sticky.
  assign hit = sticky || byte_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky <= 1'b0;
    end else if (clear) begin
      sticky <= 1'b0;
    end else if (byte_hit) begin
      sticky <= 1'b1;
    end
  end

endmodule

// File: rtl/feature_frame_packer.sv
// feature_frame_packer: assembles a stream of feature bytes into one wide
// frame register with a single-entry output slot and valid/ready handshake.
// Short frames are zero-padded, long frames are truncated and their tail
// drained; both raise a one-cycle frame_err pulse.
// Build option: define FEATURE_ANOMALY_DETECT_EN to build the anomaly
// compare; otherwise anomaly_flag is tied to 0.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   in_data/in_valid/in_last  - input byte stream, in_ready accepts
//   label_in/label_in_valid   - frame label, sampled on accepted bytes
//   features_out_flat         - packed frame, feature i at [8i+7:8i]
//   label_out/label_out_valid - latest label seen during the frame
//   out_valid/out_ready       - output slot handshake
//   anomaly_flag              - any emitted feature >= ANOM_THRESH
//   frame_err                 - one-cycle pulse on short or long frame
module feature_frame_packer
  import feature_frame_packer_pkg::*;
#(
  parameter int unsigned N_FEAT      = N_FEAT_DEF,
  parameter int unsigned FEAT_W      = FEAT_W_DEF,
  parameter int unsigned ANOM_THRESH = ANOM_THRESH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FEAT_W-1:0]        in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  input  logic [FEAT_W-1:0]        label_in,
  input  logic                     label_in_valid,
  output logic [N_FEAT*FEAT_W-1:0] features_out_flat,
  output logic [FEAT_W-1:0]        label_out,
  output logic                     label_out_valid,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     anomaly_flag,
  output logic                     frame_err
);

  localparam int unsigned      FLAT_W   = N_FEAT * FEAT_W;
  localparam int unsigned      IDX_W    = $clog2(N_FEAT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

  if (ANOM_THRESH >= (32'd1 << FEAT_W)) begin : g_thresh_range
    $error("ANOM_THRESH does not fit in FEAT_W bits");
  end

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [FLAT_W-1:0]  asm_buf;
  logic [FEAT_W-1:0]  asm_label;
  logic               asm_label_valid;
  logic               pend_drain;

  logic               hs;
  logic               fill_hs;
  logic               slot_free;
  logic               frame_done;
  logic               frame_bad;

  logic [FLAT_W-1:0]  asm_with_byte;
  logic [FEAT_W-1:0]  label_next;
  logic               label_valid_next;
  logic               load;
  logic [FLAT_W-1:0]  load_feat;
  logic [FEAT_W-1:0]  load_label;
  logic               load_label_valid;

  // PEND is the only state that refuses bytes; reset forces it low too.
  assign in_ready   = !rst && (state != PEND);
  assign hs         = in_valid && in_ready;
  assign fill_hs    = hs && (state == FILL);
  assign slot_free  = !out_valid || out_ready;
  assign frame_done = fill_hs && (in_last || (idx == LAST_IDX));
  // Exactly one of "in_last" and "buffer full" means short or long frame.
  assign frame_bad  = fill_hs && (in_last != (idx == LAST_IDX));

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // one unassigned, which would otherwise infer a latch.
    asm_with_byte    = asm_buf;
    asm_with_byte[FEAT_W*int'(idx) +: FEAT_W] = in_data;
    label_next       = label_in_valid ? label_in : asm_label;
    label_valid_next = asm_label_valid || label_in_valid;

    load             = 1'b0;
    load_feat        = asm_buf;
    load_label       = asm_label;
    load_label_valid = asm_label_valid;

    if (state == PEND) begin
      load = slot_free;
    end else if (frame_done) begin
      // Bypass the completing byte and label straight into the slot.
      load             = slot_free;
      load_feat        = asm_with_byte;
      load_label       = label_next;
      load_label_valid = label_valid_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= FILL;
      idx               <= '0;
      // NOTE: the assembly buffer is a flop vector, so it can take the async
      // reset directly; it is also cleared at every frame start below.
      asm_buf           <= '0;
      asm_label         <= '0;
      asm_label_valid   <= 1'b0;
      pend_drain        <= 1'b0;
      features_out_flat <= '0;
      label_out         <= '0;
      label_out_valid   <= 1'b0;
      out_valid         <= 1'b0;
      frame_err         <= 1'b0;
    end else begin
      frame_err <= frame_bad;

      // Output slot: a reload in the same cycle as an unload keeps valid high.
      if (load) begin
        features_out_flat <= load_feat;
        label_out         <= load_label;
        label_out_valid   <= load_label_valid;
        out_valid         <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        FILL: begin
          if (fill_hs) begin
            if (!frame_done) begin
              asm_buf         <= asm_with_byte;
              asm_label       <= label_next;
              asm_label_valid <= label_valid_next;
              idx             <= idx + 1'b1;
            end else if (slot_free) begin
              asm_buf         <= '0;
              asm_label       <= '0;
              asm_label_valid <= 1'b0;
              idx             <= '0;
              state           <= in_last ? FILL : DRAIN;
            end else begin
              // Park the finished frame until the slot frees up.
              asm_buf         <= asm_with_byte;
              asm_label       <= label_next;
              asm_label_valid <= label_valid_next;
              idx             <= '0;
              pend_drain      <= !in_last;
              state           <= PEND;
            end
          end
        end
        PEND: begin
          if (slot_free) begin
            asm_buf         <= '0;
            asm_label       <= '0;
            asm_label_valid <= 1'b0;
            state           <= pend_drain ? DRAIN : FILL;
          end
        end
        DRAIN: begin
          if (hs && in_last) begin
            state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef FEATURE_ANOMALY_DETECT_EN
  logic anom_hit;

  feature_anomaly_scan #(
    .FEAT_W (FEAT_W),
    .THRESH (ANOM_THRESH[FEAT_W-1:0])
  ) u_anomaly_scan (
    .clk    (clk),
    .rst    (rst),
    .data   (in_data),
    .sample (fill_hs),
    .clear  (load),
    .hit    (anom_hit)
  );

  // Registered alongside the frame so it always describes the slot contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anomaly_flag <= 1'b0;
    end else if (load) begin
      anomaly_flag <= anom_hit;
    end
  end
`else
  assign anomaly_flag = 1'b0;
`endif

endmodule
